fft_bitrev_reorder: RTL
=======================

FFT_BITREV_REORDER -- requirements
Module: fft_bitrev_reorder

Interface
REQ-001 SHALL have parameter DATA_W, default 11, meaning the I/Q sample width (the last dif_stage OUT_W).
REQ-002 SHALL have parameter LOG2_N, default 8, meaning log2 of the FFT length N (equals TOTAL_STAGES).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL have port i_rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port i_init, input, 1 bit: synchronous frame restart, active-high.
REQ-006 SHALL have port i_vld, input, 1 bit: input sample valid; no backpressure, gaps allowed.
REQ-007 SHALL have ports i_I and i_Q, input, DATA_W bits each, signed: the sample in bit-reversed frequency order.
REQ-008 SHALL have port o_vld, output, 1 bit: output sample valid.
REQ-009 SHALL have ports o_I and o_Q, output, DATA_W bits each, signed: the sample in natural frequency order.
REQ-010 SHALL have port o_sof, output, 1 bit: high with o_vld on bin 0 of each frame.
REQ-011 SHALL have port o_ovf_strb, output, 1 bit: one-cycle pulse when an input sample is dropped.

Function
REQ-012 SHALL hold two banks (ping-pong), each N entries of 2*DATA_W bits, with a full flag per bank.
REQ-013 SHALL, per write, store {i_I,i_Q} at address wr_cnt of bank wr_bank, then increment wr_cnt (LOG2_N bits, wraps).
REQ-014 SHALL, when wr_cnt wraps N-1 -> 0, set full[wr_bank] and toggle wr_bank in the same cycle.
REQ-015 SHALL drop the sample and pulse o_ovf_strb the next cycle if i_vld is high while full[wr_bank] is set; wr_cnt stays unchanged.
REQ-016 SHALL run the reader with two states: IDLE and DRAIN.
REQ-017 SHALL move IDLE -> DRAIN when full[rd_bank] is set, with rd_cnt = 0.
REQ-018 SHALL, in DRAIN, read bank rd_bank at address bitrev(rd_cnt) every cycle and increment rd_cnt.
REQ-019 SHALL, at rd_cnt = N-1 in DRAIN: clear full[rd_bank] and toggle rd_bank.
REQ-020 SHALL, in that same cycle, stay in DRAIN (rd_cnt = 0) if the other bank is full or is being filled this cycle, otherwise return to IDLE.
REQ-021 SHALL register the read: o_vld, o_I, o_Q and o_sof appear 1 cycle after the read address (o_sof = read of rd_cnt 0).
REQ-022 SHALL produce latency such that the last input write of a frame at cycle T gives bin 0 at T+2 and bin N-1 at T+N+1, with o_vld continuous during a frame.
REQ-023 SHALL have back-to-back frames at full rate (i_vld held high) produce continuous o_vld with no gaps and no drops.
REQ-024 SHALL give a set and a clear of the same full flag in the same cycle priority to the set (cannot occur in legal streams).
REQ-025 SHALL hold o_I/o_Q at their last value when o_vld is low.
REQ-026 SHALL pass data unchanged: no scaling and no rounding.

Reset
REQ-027 SHALL, on i_rst_n low (asynchronous) or i_init high (synchronous): set wr_cnt, rd_cnt, wr_bank and rd_bank to 0.
REQ-028 SHALL, on the same reset or i_init: clear both full flags, set the state to IDLE, and set o_vld, o_sof and o_ovf_strb to 0.
REQ-029 SHALL reset o_I and o_Q to 0; the memory contents are not reset.
REQ-030 SHALL, on i_init mid-frame, discard the partial input frame and abort any drain in the next cycle.
REQ-031 SHALL ignore an i_vld that coincides with i_init.

Structure
REQ-032 SHALL take the bit_reverse function (width-parameterised) from shared package fft_pkg, alongside the LOG2_N-derived constants.
REQ-033 SHALL instantiate one sub-module, sdp_ram: simple dual-port RAM, depth 2*N, address {bank,index}, registered read.

Verification (N=8, DATA_W=11)
REQ-034 SHALL cover: one frame with I=0..7, Q=-I, i_vld continuous -> o_I = 0,4,2,6,1,5,3,7 with Q negated, o_sof on the first output, first output 2 cycles after the last input.
REQ-035 SHALL cover: three back-to-back frames, continuous -> 24 contiguous o_vld cycles, o_sof every 8th, o_ovf_strb never high.
REQ-036 SHALL cover: a frame with i_vld gaps (1 on, 2 off) -> same order as the first scenario, output starting 2 cycles after the 8th valid.
REQ-037 SHALL cover: i_init after 5 samples, then a full frame of 100..107 -> output 100,104,102,106,101,105,103,107 only.
REQ-038 SHALL cover: i_rst_n low for 1 cycle mid-drain (asynchronous, off-edge) -> o_vld 0 immediately, and no output until 8 new samples arrive.
REQ-039 SHALL cover: extreme values -1024 and +1023 on I/Q -> passed through bit-exact.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared FFT constants and the bit-reversal helper used by the output reorder stage.
package fft_pkg;

  localparam int DATA_W_DEF = 11;
  localparam int LOG2_N_DEF = 8;
  localparam int N_DEF      = 1 << LOG2_N_DEF;
  localparam int MAX_LOG2_N = 16;

  typedef enum logic {
    RD_IDLE  = 1'b0,
    RD_DRAIN = 1'b1
  } rd_state_e;

  // Reverses the low 'width' bits of value; bits above 'width' come back as zero.
  function automatic logic [MAX_LOG2_N-1:0] bit_reverse(input logic [MAX_LOG2_N-1:0] value,
                                                        input int width);
    logic [MAX_LOG2_N-1:0] v;
    logic [MAX_LOG2_N-1:0] rev;
    v   = value;
    rev = '0;
    for (int i = 0; i < MAX_LOG2_N; i++) begin
      if (i < width) begin
        rev = {rev[MAX_LOG2_N-2:0], v[0]};
        v   = v >> 1;
      end
    end
    return rev;
  endfunction

endpackage

// File: rtl/fft_bitrev_reorder_if.sv
// Sample stream bundle of the bit-reversal reorder stage: producer side drives i_*, consumer sees o_*.
interface fft_bitrev_reorder_if
  import fft_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);

  logic                     i_init;
  logic                     i_vld;
  logic signed [DATA_W-1:0] i_I;
  logic signed [DATA_W-1:0] i_Q;
  logic                     o_vld;
  logic signed [DATA_W-1:0] o_I;
  logic signed [DATA_W-1:0] o_Q;
  logic                     o_sof;
  logic                     o_ovf_strb;

  modport master (
    output i_init, i_vld, i_I, i_Q,
    input  o_vld, o_I, o_Q, o_sof, o_ovf_strb
  );

  modport slave (
    input  i_init, i_vld, i_I, i_Q,
    output o_vld, o_I, o_Q, o_sof, o_ovf_strb
  );

endinterface

// File: rtl/fft_bitrev_reorder_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port, same clock.
module sdp_ram #(
  parameter int WIDTH  = 22,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: the array is deliberately left without reset so it maps onto block RAM;
  // only the read register below is cleared.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    rdata <= '0;
    else if (clr)  rdata <= '0;
    else if (re)   rdata <= mem[raddr];
  end

endmodule

// File: rtl/fft_bitrev_reorder.sv
// Ping-pong reorder buffer turning a bit-reversed FFT output frame into natural bin order.
module fft_bitrev_reorder
  import fft_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int LOG2_N = LOG2_N_DEF
) (
  input  logic                     clk,
  input  logic                     i_rst_n,
  input  logic                     i_init,
  input  logic                     i_vld,
  input  logic signed [DATA_W-1:0] i_I,
  input  logic signed [DATA_W-1:0] i_Q,
  output logic                     o_vld,
  output logic signed [DATA_W-1:0] o_I,
  output logic signed [DATA_W-1:0] o_Q,
  output logic                     o_sof,
  output logic                     o_ovf_strb
);

  logic [LOG2_N-1:0] wr_cnt;
  logic [LOG2_N-1:0] rd_cnt;
  logic [LOG2_N-1:0] rd_idx;
  logic              wr_bank;
  logic              rd_bank;
  logic [1:0]        full;
  logic [1:0]        full_nxt;
  rd_state_e         state;
  rd_state_e         state_nxt;

  logic wr_fire;
  logic wr_wrap;
  logic drop;
  logic rd_active;
  logic rd_last;
  logic rd_chain;

  logic [2*DATA_W-1:0] rd_data;

  always_comb begin
    wr_fire = i_vld && !i_init && !full[wr_bank];
    drop    = i_vld && !i_init &&  full[wr_bank];
    wr_wrap = wr_fire && (wr_cnt == '1);
  end

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case/if tree can leave a latch behind.
  always_comb begin
    state_nxt = state;
    rd_active = 1'b0;
    if (!i_init) begin
      case (state)
        RD_IDLE: begin
          // Bin 0 is read in the same cycle the bank is seen full, saving one cycle of latency.
          if (full[rd_bank]) begin
            rd_active = 1'b1;
            state_nxt = RD_DRAIN;
          end
        end
        RD_DRAIN: rd_active = 1'b1;
        default:  state_nxt = RD_IDLE;
      endcase
    end
    rd_last  = rd_active && (rd_cnt == '1);
    rd_chain = full[!rd_bank] || (wr_wrap && (wr_bank != rd_bank));
    if (rd_last) state_nxt = rd_chain ? RD_DRAIN : RD_IDLE;
  end

  // A set wins over a clear of the same flag.
  always_comb begin
    full_nxt = full;
    if (rd_last) full_nxt[rd_bank] = 1'b0;
    if (wr_wrap) full_nxt[wr_bank] = 1'b1;
  end

  assign rd_idx = LOG2_N'(bit_reverse(MAX_LOG2_N'(rd_cnt), LOG2_N));

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n)    state <= RD_IDLE;
    else if (i_init) state <= RD_IDLE;
    else             state <= state_nxt;
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_cnt     <= '0;
      rd_cnt     <= '0;
      wr_bank    <= 1'b0;
      rd_bank    <= 1'b0;
      full       <= '0;
      o_vld      <= 1'b0;
      o_sof      <= 1'b0;
      o_ovf_strb <= 1'b0;
    end else if (i_init) begin
      wr_cnt     <= '0;
      rd_cnt     <= '0;
      wr_bank    <= 1'b0;
      rd_bank    <= 1'b0;
      full       <= '0;
      o_vld      <= 1'b0;
      o_sof      <= 1'b0;
      o_ovf_strb <= 1'b0;
    end else begin
      if (wr_fire)   wr_cnt  <= wr_cnt + 1'b1;
      if (wr_wrap)   wr_bank <= !wr_bank;
      if (rd_active) rd_cnt  <= rd_cnt + 1'b1;
      if (rd_last)   rd_bank <= !rd_bank;
      full       <= full_nxt;
      o_vld      <= rd_active;
      o_sof      <= rd_active && (rd_cnt == '0);
      o_ovf_strb <= drop;
    end
  end

  sdp_ram #(
    .WIDTH  (2*DATA_W),
    .ADDR_W (LOG2_N+1)
  ) u_ram (
    .clk   (clk),
    .rst_n (i_rst_n),
    .clr   (i_init),
    .we    (wr_fire),
    .waddr ({wr_bank, wr_cnt}),
    .wdata ({i_I, i_Q}),
    .re    (rd_active),
    .raddr ({rd_bank, rd_idx}),
    .rdata (rd_data)
  );

  assign o_I = rd_data[2*DATA_W-1:DATA_W];
  assign o_Q = rd_data[DATA_W-1:0];

endmodule
